moving_avg_sink: RTL and testbench
==================================

# moving_avg_sink

Receiving end of the moving-average filter's output stream. Captures each `data_out`/`e_out` sample into a small first-word-fall-through FIFO. Reports per-frame statistics (min, max, sample count) when the enable run ends. Gives the downstream consumer (UART formatter, display driver) a pop-style read port, so it can drain results at its own pace.

## Interface
Parameters:
- `WIDTH`, 10: sample width; matches the filter output.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `CNT_W`, 8: width of the frame sample counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `RST`, input, 1: synchronous reset, active-high.
- `data_in`, input, WIDTH: sample from the filter's `data_out`.
- `e_in`, input, 1: sample-valid from the filter's `e_out`; a contiguous high run is one frame.
- `rd_en`, input, 1: pop request from the consumer.
- `clr_ovf`, input, 1: clears the sticky overflow flag.
- `data_out`, output, WIDTH: FIFO head entry; valid while `valid_out` is 1.
- `valid_out`, output, 1: FIFO not empty.
- `full`, output, 1: FIFO holds DEPTH entries.
- `ovf`, output, 1: sticky flag; set when a sample was dropped.
- `frame_done`, output, 1: one-cycle pulse when a frame ends.
- `frame_min`, output, WIDTH: minimum sample of the last completed frame.
- `frame_max`, output, WIDTH: maximum sample of the last completed frame.
- `frame_cnt`, output, CNT_W: samples in the last completed frame; saturating.

## Operation
- FSM states:
  - IDLE: `e_in`=0.
  - ACT: collecting a frame.
  - RPT: one reporting cycle.
- FSM transitions:
  - IDLE to ACT when a rising edge samples `e_in`=1.
  - ACT stays in ACT while `e_in`=1.
  - ACT to RPT on the first edge that samples `e_in`=0.
  - RPT to ACT if `e_in`=1 at that edge, which starts a new frame with that sample; otherwise RPT to IDLE.
- Write side:
  - Every edge with `e_in`=1 writes `data_in`, if the FIFO is not full or a pop occurs at the same edge.
  - Otherwise the sample is dropped and `ovf` is set.
  - A dropped sample still counts in the frame statistics.
- Read side:
  - Pop when `rd_en`=1 and `valid_out`=1.
  - `rd_en` on an empty FIFO is ignored and does not change state.
- Simultaneous push and pop:
  - When full: both take effect, and the FIFO stays full.
  - When empty: only the push takes effect, because `valid_out`=0.
- Frame statistics:
  - Running min, max and count are kept during ACT.
  - The first sample of a frame loads min = max = sample and count = 1.
  - Count saturates at 2^CNT_W−1.
  - On the ACT-to-RPT edge the running values are copied into `frame_min`, `frame_max` and `frame_cnt`, which then hold until the next RPT.
- `ovf` clearing:
  - `ovf` clears only on `clr_ovf` or `RST`.
  - If `clr_ovf` and a drop occur at the same edge, `ovf` stays 1.
- Arithmetic:
  - Min and max comparisons are unsigned.
  - FIFO pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty, and pointers wrap naturally.

## Timing
- Reset values (`RST` sampled high):
  - FSM in IDLE.
  - Pointers at 0, so `valid_out`=0 and `full`=0.
  - `ovf`=0 and `frame_done`=0.
  - `frame_min`, `frame_max`, `frame_cnt` = 0.
  - `data_out`=0 is not guaranteed; it is don't-care while `valid_out`=0.
- Reset mid-frame discards the FIFO contents and the partial frame. No `frame_done` is emitted.
- Write-to-read latency: a sample written at edge k sets `valid_out`=1 after edge k, so the head is readable in cycle k+1.
- `data_out` is first-word-fall-through: the head appears combinationally from the memory at the read pointer. After a pop at edge k, the next entry is on `data_out` in cycle k+1.
- `frame_done` is high for exactly the cycle following the edge that moved the FSM into RPT. Statistics are valid in that same cycle.
- A one-sample frame (`e_in` high for one edge) reports count = 1 and min = max = that sample.

## Structure
- A shared package holds:
  - the FSM state encoding: IDLE=2'd0, ACT=2'd1, RPT=2'd2;
  - defaults for WIDTH and DEPTH, shared with `moving_avg`.
- One sub-module, `sync_fifo_fwft` (parameters WIDTH and DEPTH; push, pop, full and empty flags), instantiated once.
- Frame statistics and the FSM live in the top level.

## Test plan
- Reset, then a single frame of samples 80, 60, 75, 68, 55:
  - `frame_done` pulses one cycle after `e_in` falls.
  - `frame_min`=55, `frame_max`=80, `frame_cnt`=5.
  - Popping yields 80, 60, 75, 68, 55 in order.
- With `rd_en`=0, push 10 samples into the DEPTH=8 FIFO:
  - `full`=1 after the 8th sample; samples 9 and 10 are dropped.
  - `ovf`=1, while `frame_cnt`=10.
  - `clr_ovf` pulse returns `ovf` to 0.
- With the FIFO full, hold `e_in`=1 and `rd_en`=1 together:
  - No drops occur, and `full` stays 1.
  - The output order is preserved across pointer wrap-around.
- Back-to-back frames 90, 70 then 10, 5, 9, with `e_in` low for exactly one cycle between them:
  - Two `frame_done` pulses.
  - First frame: min 70, max 90, count 2.
  - Second frame: min 5, max 10, count 3.
- Assert `RST` mid-frame after 3 samples:
  - All outputs return to their reset values.
  - No `frame_done` pulse.
  - The next frame (sample 88) reports count 1, min = max = 88.
- `rd_en`=1 while empty: `valid_out` stays 0, the pointers do not change, and the next push is read back correctly.

Source files
------------

// File: rtl/moving_avg_sink_pkg.sv
// Shared definitions for the moving-average sink: FSM encoding and the
// default sample/FIFO geometry shared with the moving_avg filter.
package moving_avg_sink_pkg;

    localparam int DEFAULT_WIDTH = 10;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACT  = 2'd1,
        RPT  = 2'd2
    } sink_state_t;

endpackage

// File: rtl/moving_avg_sink_if.sv
// Stream/read-port bundle between the filter, the sink and its consumer.
// The master side drives the filter samples and the consumer controls;
// the slave side (the sink) returns FIFO head, flags and frame statistics.
interface moving_avg_sink_if #(
    parameter int WIDTH = moving_avg_sink_pkg::DEFAULT_WIDTH,
    parameter int CNT_W = moving_avg_sink_pkg::DEFAULT_CNT_W
);
    logic [WIDTH-1:0] data_in;
    logic             e_in;
    logic             rd_en;
    logic             clr_ovf;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             ovf;
    logic             frame_done;
    logic [WIDTH-1:0] frame_min;
    logic [WIDTH-1:0] frame_max;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output data_in, e_in, rd_en, clr_ovf,
        input  data_out, valid_out, full, ovf,
        input  frame_done, frame_min, frame_max, frame_cnt
    );

    modport slave (
        input  data_in, e_in, rd_en, clr_ovf,
        output data_out, valid_out, full, ovf,
        output frame_done, frame_min, frame_max, frame_cnt
    );
endinterface

// File: rtl/moving_avg_sink_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is presented
// combinationally at the read pointer; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module sync_fifo_fwft
    import moving_avg_sink_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when the head is leaving at the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/moving_avg_sink.sv
// Receiving end of the moving-average filter: buffers samples in a FWFT
// FIFO for a pop-style consumer, flags dropped samples, and reports
// min/max/count for each contiguous e_in run (frame).
module moving_avg_sink
    import moving_avg_sink_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             RST,
    moving_avg_sink_if.slave bus
);
    sink_state_t      state;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_ok;
    logic             drop;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] run_max;
    logic [CNT_W-1:0] run_cnt;
    logic [WIDTH-1:0] frame_min_r;
    logic [WIDTH-1:0] frame_max_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             frame_done_r;
    logic             ovf_r;

    // Frame counter saturates at its all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    sync_fifo_fwft #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (RST),
        .push    (bus.e_in),
        .pop     (bus.rd_en),
        .wr_data (bus.data_in),
        .rd_data (bus.data_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A sample is lost only when the FIFO is full and nothing leaves.
    assign pop_ok = bus.rd_en & ~fifo_empty;
    assign drop   = bus.e_in & fifo_full & ~pop_ok;

    assign bus.valid_out  = ~fifo_empty;
    assign bus.full       = fifo_full;
    assign bus.ovf        = ovf_r;
    assign bus.frame_done = frame_done_r;
    assign bus.frame_min  = frame_min_r;
    assign bus.frame_max  = frame_max_r;
    assign bus.frame_cnt  = frame_cnt_r;

    // Frame FSM: publishes the running statistics and pulses frame_done
    // on the edge that sees e_in fall.
    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            frame_done_r <= 1'b0;
            frame_min_r  <= '0;
            frame_max_r  <= '0;
            frame_cnt_r  <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                IDLE: if (bus.e_in) state <= ACT;
                ACT: begin
                    if (!bus.e_in) begin
                        state        <= RPT;
                        frame_done_r <= 1'b1;
                        frame_min_r  <= run_min;
                        frame_max_r  <= run_max;
                        frame_cnt_r  <= run_cnt;
                    end
                end
                RPT:     state <= bus.e_in ? ACT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Running statistics: the first sample of a frame (seen outside ACT)
    // reloads them, later samples fold in with unsigned compares.
    always_ff @(posedge clk) begin
        if (bus.e_in) begin
            if (state == ACT) begin
                if (bus.data_in < run_min) run_min <= bus.data_in;
                if (bus.data_in > run_max) run_max <= bus.data_in;
                run_cnt <= sat_inc(run_cnt);
            end else begin
                run_min <= bus.data_in;
                run_max <= bus.data_in;
                run_cnt <= CNT_W'(1);
            end
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (RST)              ovf_r <= 1'b0;
        else if (drop)        ovf_r <= 1'b1;
        else if (bus.clr_ovf) ovf_r <= 1'b0;
    end
endmodule

// File: tb/tb_moving_avg_sink.sv
// Self-checking bench for moving_avg_sink: directed scenarios plus random
// traffic, checked against a queue-based behavioural model.
module tb_moving_avg_sink;
    localparam int WIDTH = 10;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic RST;
    moving_avg_sink_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    moving_avg_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Behavioural model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] fs[$];
    bit               m_ovf, m_fd, m_inf;
    logic [WIDTH-1:0] m_min, m_max;
    logic [CNT_W-1:0] m_cnt;

    // Apply one cycle of inputs, let the edge happen, advance the model.
    task automatic tick(input bit r, input bit e, input logic [WIDTH-1:0] d,
                        input bit rd, input bit clr);
        bit pop, drop;
        RST = r; bus.e_in = e; bus.data_in = d; bus.rd_en = rd; bus.clr_ovf = clr;
        @(posedge clk);
        if (r) begin
            mq.delete(); fs.delete();
            m_ovf = 0; m_fd = 0; m_inf = 0; m_min = '0; m_max = '0; m_cnt = '0;
        end else begin
            pop  = rd && (mq.size() != 0);
            drop = e && (mq.size() == DEPTH) && !pop;
            if (pop) void'(mq.pop_front());
            if (e && !drop) mq.push_back(d);
            if (drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_fd = 0;
            if (e) begin
                if (!m_inf) fs.delete();
                fs.push_back(d);
                m_inf = 1;
            end else if (m_inf) begin
                m_inf = 0;
                m_fd  = 1;
                m_min = fs[0];
                m_max = fs[0];
                foreach (fs[i]) begin
                    if (fs[i] < m_min) m_min = fs[i];
                    if (fs[i] > m_max) m_max = fs[i];
                end
                m_cnt = (fs.size() > 255) ? 8'd255 : CNT_W'(fs.size());
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.valid_out); end
        n_cmp++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd: got %b want 0", bus.frame_done); end
        n_cmp++; if ({bus.frame_min, bus.frame_max, bus.frame_cnt} !== '0) begin
            n_fail++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", bus.frame_min, bus.frame_max, bus.frame_cnt);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_single_frame();
        logic [WIDTH-1:0] s[5] = '{80, 60, 75, 68, 55};
        for (int i = 0; i < 5; i++) tick(0, 1, s[i], 0, 0);
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL sf_fd_early: got %b want 0", bus.frame_done); end
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL sf_fd: got %b want 1", bus.frame_done); end
        n_cmp++; if (bus.frame_min !== 10'd55) begin n_fail++; $display("FAIL sf_min: got %0d want 55", bus.frame_min); end
        n_cmp++; if (bus.frame_max !== 10'd80) begin n_fail++; $display("FAIL sf_max: got %0d want 80", bus.frame_max); end
        n_cmp++; if (bus.frame_cnt !== 8'd5) begin n_fail++; $display("FAIL sf_cnt: got %0d want 5", bus.frame_cnt); end
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL sf_fd_pulse: got %b want 0", bus.frame_done); end
        n_cmp++; if (bus.frame_cnt !== 8'd5) begin n_fail++; $display("FAIL sf_cnt_hold: got %0d want 5", bus.frame_cnt); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== s[i]) begin
                n_fail++; $display("FAIL sf_pop%0d: got %0d (valid %b) want %0d", i, bus.data_out, bus.valid_out, s[i]);
            end
            tick(0, 0, 0, 1, 0);
        end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL sf_empty: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 10; i++) begin
            tick(0, 1, WIDTH'($urandom), 0, 0);
            if (i == 8) begin
                n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ov_full8: got %b want 1", bus.full); end
                n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ov_ovf8: got %b want 0", bus.ovf); end
            end
        end
        n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ov_ovf: got %b want 1", bus.ovf); end
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (bus.frame_cnt !== 8'd10) begin n_fail++; $display("FAIL ov_cnt: got %0d want 10", bus.frame_cnt); end
        n_cmp++; if (bus.frame_min !== m_min || bus.frame_max !== m_max) begin
            n_fail++; $display("FAIL ov_minmax: got %0d/%0d want %0d/%0d", bus.frame_min, bus.frame_max, m_min, m_max);
        end
        n_cmp++; if (bus.data_out !== mq[0]) begin n_fail++; $display("FAIL ov_head: got %0d want %0d", bus.data_out, mq[0]); end
        tick(0, 0, 0, 0, 1);
        n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ov_clr: got %b want 0", bus.ovf); end
        n_cmp++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ov_still_full: got %b want 1", bus.full); end
    endtask

    task automatic test_full_stream();
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (bus.data_out !== mq[0]) begin
                n_fail++; $display("FAIL fs_head%0d: got %0d want %0d", i, bus.data_out, mq[0]);
            end
            tick(0, 1, WIDTH'($urandom), 1, 0);
            n_cmp++; if (bus.full !== 1'b1 || bus.ovf !== 1'b0) begin
                n_fail++; $display("FAIL fs_flags%0d: got full %b ovf %b want 1 0", i, bus.full, bus.ovf);
            end
        end
        for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) begin
            n_cmp++; if (bus.data_out !== mq[0]) begin
                n_fail++; $display("FAIL fs_drain%0d: got %0d want %0d", i, bus.data_out, mq[0]);
            end
            tick(0, 0, 0, 1, 0);
            if (i == 0) begin
                n_cmp++; if (bus.frame_done !== 1'b1 || bus.frame_cnt !== m_cnt || bus.frame_min !== m_min || bus.frame_max !== m_max) begin
                    n_fail++; $display("FAIL fs_stats: got %b %0d %0d %0d want 1 %0d %0d %0d", bus.frame_done,
                                       bus.frame_cnt, bus.frame_min, bus.frame_max, m_cnt, m_min, m_max);
                end
            end
        end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL fs_empty: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] s[5] = '{90, 70, 10, 5, 9};
        int pulses = 0;
        tick(0, 1, 90, 0, 0); pulses += int'(bus.frame_done);
        tick(0, 1, 70, 0, 0); pulses += int'(bus.frame_done);
        tick(0, 0, 0, 0, 0);  pulses += int'(bus.frame_done);
        n_cmp++; if (bus.frame_min !== 10'd70 || bus.frame_max !== 10'd90 || bus.frame_cnt !== 8'd2) begin
            n_fail++; $display("FAIL b2b_f1: got %0d/%0d/%0d want 70/90/2", bus.frame_min, bus.frame_max, bus.frame_cnt);
        end
        tick(0, 1, 10, 0, 0); pulses += int'(bus.frame_done);
        tick(0, 1, 5, 0, 0);  pulses += int'(bus.frame_done);
        tick(0, 1, 9, 0, 0);  pulses += int'(bus.frame_done);
        tick(0, 0, 0, 0, 0);  pulses += int'(bus.frame_done);
        n_cmp++; if (bus.frame_min !== 10'd5 || bus.frame_max !== 10'd10 || bus.frame_cnt !== 8'd3) begin
            n_fail++; $display("FAIL b2b_f2: got %0d/%0d/%0d want 5/10/3", bus.frame_min, bus.frame_max, bus.frame_cnt);
        end
        tick(0, 0, 0, 0, 0);  pulses += int'(bus.frame_done);
        n_cmp++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.data_out !== s[i]) begin n_fail++; $display("FAIL b2b_pop%0d: got %0d want %0d", i, bus.data_out, s[i]); end
            tick(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pulses = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, WIDTH'($urandom), 0, 0);
        tick(1, 1, WIDTH'($urandom), 0, 0);
        n_cmp++; if (bus.valid_out !== 1'b0 || bus.full !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL rm_flags: got valid %b full %b ovf %b want 0 0 0", bus.valid_out, bus.full, bus.ovf);
        end
        n_cmp++; if ({bus.frame_min, bus.frame_max, bus.frame_cnt} !== '0) begin
            n_fail++; $display("FAIL rm_stats: got %0d/%0d/%0d want 0/0/0", bus.frame_min, bus.frame_max, bus.frame_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            pulses += int'(bus.frame_done);
            tick(0, 0, 0, 0, 0);
        end
        pulses += int'(bus.frame_done);
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rm_nofd: got %0d pulses want 0", pulses); end
        tick(0, 1, 88, 0, 0);
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (bus.frame_done !== 1'b1 || bus.frame_cnt !== 8'd1 || bus.frame_min !== 10'd88 || bus.frame_max !== 10'd88) begin
            n_fail++; $display("FAIL rm_one: got %b %0d/%0d/%0d want 1 88/88/1", bus.frame_done,
                               bus.frame_min, bus.frame_max, bus.frame_cnt);
        end
        n_cmp++; if (bus.data_out !== 10'd88 || bus.valid_out !== 1'b1) begin
            n_fail++; $display("FAIL rm_head: got %0d (valid %b) want 88", bus.data_out, bus.valid_out);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_rd_empty();
        logic [WIDTH-1:0] x = WIDTH'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 0);
            n_cmp++; if (bus.valid_out !== 1'b0 || bus.full !== 1'b0) begin
                n_fail++; $display("FAIL re_idle%0d: got valid %b full %b want 0 0", i, bus.valid_out, bus.full);
            end
        end
        tick(0, 1, x, 1, 0);
        n_cmp++; if (bus.valid_out !== 1'b1 || bus.data_out !== x) begin
            n_fail++; $display("FAIL re_push: got %0d (valid %b) want %0d", bus.data_out, bus.valid_out, x);
        end
        tick(0, 0, 0, 0, 0);
        n_cmp++; if (bus.data_out !== x) begin n_fail++; $display("FAIL re_hold: got %0d want %0d", bus.data_out, x); end
        tick(0, 0, 0, 1, 0);
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL re_drained: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) tick(0, 1, WIDTH'($urandom), 1, 0);
        tick(0, 0, 0, 1, 0);
        n_cmp++; if (bus.frame_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", bus.frame_cnt); end
        n_cmp++; if (bus.frame_min !== m_min || bus.frame_max !== m_max) begin
            n_fail++; $display("FAIL sat_minmax: got %0d/%0d want %0d/%0d", bus.frame_min, bus.frame_max, m_min, m_max);
        end
        n_cmp++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL sat_empty: got %b want 0", bus.valid_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 65), WIDTH'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
            n_cmp++; if (bus.valid_out !== (mq.size() != 0) || bus.full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_flags%0d: got valid %b full %b want size %0d", i, bus.valid_out, bus.full, mq.size());
            end
            n_cmp++; if (bus.ovf !== m_ovf || bus.frame_done !== m_fd) begin
                n_fail++; $display("FAIL rnd_ovf_fd%0d: got %b %b want %b %b", i, bus.ovf, bus.frame_done, m_ovf, m_fd);
            end
            n_cmp++; if (bus.frame_min !== m_min || bus.frame_max !== m_max || bus.frame_cnt !== m_cnt) begin
                n_fail++; $display("FAIL rnd_stats%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, bus.frame_min,
                                   bus.frame_max, bus.frame_cnt, m_min, m_max, m_cnt);
            end
            if (mq.size() != 0) begin
                n_cmp++; if (bus.data_out !== mq[0]) begin
                    n_fail++; $display("FAIL rnd_head%0d: got %0d want %0d", i, bus.data_out, mq[0]);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        RST = 1'b1;
        bus.e_in = 1'b0; bus.data_in = '0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_full_stream();
        test_back_to_back();
        test_reset_mid_frame();
        test_rd_empty();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
